// File: rtl/bcd_display_scanner_if.sv
// Conversion request/result and digit-scan bundle.
// master: requester/display side; slave: scanner.
interface bcd_display_scanner_if;
    logic        start;
    logic [8:0]  sum;
    logic        busy;
    logic        done;
    logic [15:0] bcd_all;
    logic [1:0]  sel;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        blank;

    modport master (
        output start, sum,
        input  busy, done, bcd_all, sel, bcd, an, blank
    );

    modport slave (
        input  start, sum,
        output busy, done, bcd_all, sel, bcd, an, blank
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// Serial double-dabble 9-bit to BCD converter and 4-digit display scanner.
// Ports: clk, rst_n (async low), bus (start/sum in; busy/done/bcd_all/sel/bcd/an/blank out).
module bcd_display_scanner #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_display_scanner_if.slave bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [8:0]    bin_q;
    logic [15:0]   acc_q;
    logic [15:0]   acc_adj;
    logic [3:0]    cnt_q;
    logic [15:0]   bcd_all_q;
    logic          done_q;
    logic [CW-1:0] rcnt_q;
    logic [1:0]    sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CONVERT;
            CONVERT: if (cnt_q == 4'd8) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // add-3 correction per nibble, no carry between nibbles
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] > 4'd4)
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            bcd_all_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bin_q <= bus.sum;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                CONVERT: begin
                    acc_q <= {acc_adj[14:0], bin_q[8]};
                    bin_q <= {bin_q[7:0], 1'b0};
                    cnt_q <= cnt_q + 4'd1;
                end
                COMMIT: begin
                    bcd_all_q <= acc_q;
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // free-running digit scan, independent of the converter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= '0;
            sel_q  <= 2'b00;
        end else if (rcnt_q == CW'(REFRESH_DIV - 1)) begin
            rcnt_q <= '0;
            sel_q  <= sel_q + 2'b01;
        end else begin
            rcnt_q <= rcnt_q + 1'b1;
        end
    end

    // decoded from sel so anode, digit and blank switch together
    always_comb begin
        bus.bcd   = bcd_all_q[3:0];
        bus.an    = 4'b1110;
        bus.blank = 1'b0;
        unique case (sel_q)
            2'b00: begin
                bus.bcd   = bcd_all_q[15:12];
                bus.an    = 4'b0111;
                bus.blank = (bcd_all_q[15:12] == 4'd0);
            end
            2'b01: begin
                bus.bcd   = bcd_all_q[11:8];
                bus.an    = 4'b1011;
                bus.blank = (bcd_all_q[15:8] == 8'd0);
            end
            2'b10: begin
                bus.bcd   = bcd_all_q[7:4];
                bus.an    = 4'b1101;
                bus.blank = (bcd_all_q[15:4] == 12'd0);
            end
            2'b11: begin
                bus.bcd   = bcd_all_q[3:0];
                bus.an    = 4'b1110;
                bus.blank = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.bcd_all = bcd_all_q;
    assign bus.sel     = sel_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized self-checking bench for bcd_display_scanner.
// Decimal reference model computed with plain arithmetic.
module tb_bcd_display_scanner;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    int   ncyc = 0;
    int   cur_val = 0;
    int   pw[4] = '{1000, 100, 10, 1};

    bcd_display_scanner_if bus();

    bcd_display_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // posedges since reset release: drives the expected scan position
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    function automatic logic [15:0] ref_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // caller must be at a negedge; returns at negedge after edge k+10
    task automatic do_convert(input int v, input string tag);
        int bad;
        bus.sum   = 9'(v);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bad = 0;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
        for (int j = 1; j < 10; j++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL %s busy_window: %0d bad cycles, want 0", tag, bad);
        else
            passed++;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1 ||
            bus.bcd_all !== ref_bcd(v))
            $display("FAIL %s commit: busy=%b done=%b bcd_all=%h want 0 1 %h",
                     tag, bus.busy, bus.done, bus.bcd_all, ref_bcd(v));
        else
            passed++;
        cur_val = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_all !== 16'h0000 ||
            bus.sel !== 2'b00 || bus.an !== 4'b0111 || bus.blank !== 1'b1 ||
            bus.bcd !== 4'h0)
            $display("FAIL reset: busy=%b done=%b all=%h sel=%b an=%b blank=%b bcd=%h",
                     bus.busy, bus.done, bus.bcd_all, bus.sel, bus.an,
                     bus.blank, bus.bcd);
        else
            passed++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_all !== 16'h0000 ||
            bus.sel !== 2'b00 || bus.an !== 4'b0111 || bus.blank !== 1'b1)
            $display("FAIL reset_stable: busy=%b done=%b all=%h sel=%b an=%b blank=%b",
                     bus.busy, bus.done, bus.bcd_all, bus.sel, bus.an, bus.blank);
        else
            passed++;
        cur_val = 0;
    endtask

    task automatic test_scan(input int cycles, input string tag);
        int s;
        logic [3:0] e_bcd;
        logic [3:0] e_an;
        logic [3:0] one;
        logic       e_blank;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            s       = (ncyc / DIV) % 4;
            e_bcd   = 4'((cur_val / pw[s]) % 10);
            e_blank = (s < 3) && (cur_val < pw[s]);
            one     = 4'b1000 >> s;
            e_an    = ~one;
            total++;
            if (bus.sel !== 2'(s) || bus.an !== e_an || bus.bcd !== e_bcd ||
                bus.blank !== e_blank)
                $display("FAIL %s scan: sel=%b an=%b bcd=%h blank=%b want %b %b %h %b",
                         tag, bus.sel, bus.an, bus.bcd, bus.blank,
                         2'(s), e_an, e_bcd, e_blank);
            else
                passed++;
        end
    endtask

    task automatic test_convert();
        int vals[4] = '{255, 511, 0, 9};
        @(negedge clk);
        foreach (vals[i]) do_convert(vals[i], "directed");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            do_convert(int'($urandom_range(0, 511)), "random");
            test_scan(3, "random");
        end
    endtask

    task automatic test_display();
        int vals[3] = '{255, 7, 40};
        foreach (vals[i]) begin
            @(negedge clk);
            do_convert(vals[i], "display");
            test_scan(4 * DIV + 3, "display");
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        do_convert(321, "b2b_a");
        do_convert(88, "b2b_b");
        do_convert(int'($urandom_range(0, 511)), "b2b_c");
    endtask

    task automatic test_start_ignored();
        int dones;
        @(negedge clk);
        bus.sum   = 9'd100;
        bus.start = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        bus.sum = 9'd300;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        total++;
        if (dones != 1 || bus.bcd_all !== 16'h0100)
            $display("FAIL ignore_start: dones=%0d bcd_all=%h want 1 0100",
                     dones, bus.bcd_all);
        else
            passed++;
        cur_val = 100;
        do_convert(300, "after_ignore");
    endtask

    task automatic test_reset_abort();
        int dones;
        @(negedge clk);
        do_convert(123, "pre_abort");
        @(negedge clk);
        bus.sum   = 9'd456;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_all !== 16'h0000 ||
            bus.sel !== 2'b00)
            $display("FAIL abort: busy=%b done=%b all=%h sel=%b want 0 0 0000 00",
                     bus.busy, bus.done, bus.bcd_all, bus.sel);
        else
            passed++;
        @(negedge clk);
        rst_n = 1'b1;
        cur_val = 0;
        dones = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || bus.bcd_all !== 16'h0000)
            $display("FAIL abort_quiet: dones=%0d bcd_all=%h want 0 0000",
                     dones, bus.bcd_all);
        else
            passed++;
        do_convert(456, "restart");
        test_scan(4 * DIV, "restart");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sum   = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_convert();
        test_display();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
